// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte-stream bus of uart_tx_arbiter: one valid/data/last/ready lane per requester.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing the uart_core transmit path, with idle timeout and
// one write pulse per byte paced on the core's tx_ready handshake.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  uart_tx_arbiter_if.slave     req,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o,
  output logic                 timeout_evt_o,
  input  logic                 tx_ready_i,
  output logic [7:0]           tx_data_o,
  output logic                 data_write_en_o
);

  localparam int unsigned IW = $clog2(N_REQ);
  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t               state, state_n;
  idx_t                 owner, owner_n, rr_ptr, rr_n, pick, cand, owner_inc;
  logic                 found, to_hit, accept;
  logic [TIMEOUT_W-1:0] cnt, cnt_n;
  logic                 last_q, last_n;
  logic [N_REQ-1:0]     grant_n, ready;
  logic [7:0]           data_n;
  logic                 we_n, evt_n;

  // First valid requester at or after rr_ptr, with wrap-around.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = idx_t'((32'(rr_ptr) + i) % N_REQ);
      if (!found && req.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign owner_inc = (32'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
  assign to_hit    = (state == GRANT) && (timeout_i != '0) && (cnt == timeout_i);
  assign busy_o    = (state != IDLE);

  // Ready is suppressed when the grant is about to be dropped so no byte is lost.
  always_comb begin
    ready = '0;
    if (state == GRANT && enable_i && !to_hit)
      ready[owner] = req.req_valid[owner] & tx_ready_i;
  end

  assign req.req_ready = ready;
  assign accept        = |ready;

  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr_ptr;
    grant_n = grant_o;
    cnt_n   = cnt;
    last_n  = last_q;
    data_n  = tx_data_o;
    we_n    = 1'b0;
    evt_n   = 1'b0;
    if (!enable_i) begin
      state_n = IDLE;
      grant_n = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            owner_n        = pick;
            grant_n        = '0;
            grant_n[pick]  = 1'b1;
            cnt_n          = '0;
            state_n        = GRANT;
          end
        end
        GRANT: begin
          if (to_hit) begin
            state_n = IDLE;
            grant_n = '0;
            rr_n    = owner_inc;
            evt_n   = 1'b1;
          end else if (accept) begin
            data_n  = req.req_data[32'(owner)*8 +: 8];
            we_n    = 1'b1;
            last_n  = req.req_last[owner];
            cnt_n   = '0;
            state_n = ACK;
          end else if (!req.req_valid[owner] && cnt != '1) begin
            // Only owner idleness counts; core back-pressure holds the counter.
            cnt_n = cnt + 1'b1;
          end
        end
        ACK: begin
          if (last_q) begin
            state_n = IDLE;
            grant_n = '0;
            rr_n    = owner_inc;
          end else begin
            state_n = GRANT;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= IDLE;
      owner           <= '0;
      rr_ptr          <= '0;
      grant_o         <= '0;
      cnt             <= '0;
      last_q          <= 1'b0;
      tx_data_o       <= '0;
      data_write_en_o <= 1'b0;
      timeout_evt_o   <= 1'b0;
    end else begin
      state           <= state_n;
      owner           <= owner_n;
      rr_ptr          <= rr_n;
      grant_o         <= grant_n;
      cnt             <= cnt_n;
      last_q          <= last_n;
      tx_data_o       <= data_n;
      data_write_en_o <= we_n;
      timeout_evt_o   <= evt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets push expected writes/events,
// a negedge monitor pops and compares them and checks the handshake invariants.
module tb_uart_tx_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned TW = 8;  // narrow counter so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          tx_ready = 1'b0;
  logic [TW-1:0] timeout = '0;
  logic [N-1:0]  grant;
  logic          busy, evt, dwe;
  logic [7:0]    tx_data;

  uart_tx_arbiter_if #(.N_REQ(N)) ifc ();

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_W(TW)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .enable_i        (enable),
    .timeout_i       (timeout),
    .req             (ifc),
    .grant_o         (grant),
    .busy_o          (busy),
    .timeout_evt_o   (evt),
    .tx_ready_i      (tx_ready),
    .tx_data_o       (tx_data),
    .data_write_en_o (dwe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int         owner;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         evt_q[$];
  logic [8:0] rq[N][$];
  logic [N-1:0] acc;
  logic       txr_s;

  task automatic expect_wr(input int o, input logic [7:0] d);
    wr_t w;
    w.owner = o;
    w.data  = d;
    exp_q.push_back(w);
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic last);
    rq[k].push_back({last, d});
  endtask

  // Requester model: holds each byte until it is accepted.
  initial begin
    ifc.req_valid = '0;
    ifc.req_data  = '0;
    ifc.req_last  = '0;
    acc   = '0;
    txr_s = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      acc   = ifc.req_valid & ifc.req_ready;
      txr_s = tx_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        if (rq[k].size() > 0) begin
          ifc.req_valid[k]      = 1'b1;
          ifc.req_data[8*k +: 8] = rq[k][0][7:0];
          ifc.req_last[k]       = rq[k][0][8];
        end else begin
          ifc.req_valid[k] = 1'b0;
          ifc.req_last[k]  = 1'b0;
        end
      end
    end
  end

  // Monitor
  wr_t  mw;
  logic dwe_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dwe_prev = 1'b0;
      end else begin
        chk("grant_onehot", 64'($countones(grant) <= 1), 1);
        chk("ready_subset", 64'(ifc.req_ready & ~grant), 0);
        if (dwe) begin
          chk("dwe_gap", dwe_prev, 0);
          chk("dwe_after_ready", txr_s, 1);
          if (exp_q.size() == 0) chk("unexpected_write", exp_q.size(), 1);
          else begin
            mw = exp_q.pop_front();
            chk("wr_data", tx_data, mw.data);
            chk("wr_owner", grant, 64'(1) << mw.owner);
          end
        end
        if (evt) begin
          if (evt_q.size() == 0) chk("unexpected_evt", evt_q.size(), 1);
          else chk("evt_cycle", cyc, evt_q.pop_front());
        end
        dwe_prev = dwe;
      end
    end
  end

  task automatic wait_dwe(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dwe) begin
        c = cyc;
        break;
      end
    end
    chk("wait_write", c >= 0, 1);
  endtask

  task automatic wait_evt(input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (evt) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_evt", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    bit empty;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      empty = 1'b1;
      for (int k = 0; k < N; k++) if (rq[k].size() != 0) empty = 1'b0;
      if (!busy && empty && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  int p;
  int pulses;
  int bad;
  bit seen;

  initial begin
    enable   = 1'b1;
    tx_ready = 1'b1;
    timeout  = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_dwe", dwe, 0);
    chk("rst_evt", evt, 0);
    chk("rst_ready", ifc.req_ready, 0);
    #1 rst_n = 1'b1;

    // 1: single byte timing
    @(negedge clk);
    #1 send(0, 8'h55, 1'b1);
    expect_wr(0, 8'h55);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifc.req_valid[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t1_valid_seen", seen, 1);
    chk("t1_grant_idle", grant, 0);
    chk("t1_ready_idle", ifc.req_ready, 0);
    @(negedge clk);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_ready", ifc.req_ready, 4'b0001);
    @(negedge clk);
    chk("t1_pulse", dwe, 1);
    chk("t1_ack_ready", ifc.req_ready, 0);
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_grant", grant, 0);

    // 2: contention and round-robin from reset
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    send(0, 8'h10, 1'b0); send(0, 8'h11, 1'b0); send(0, 8'h12, 1'b1);
    send(2, 8'h20, 1'b0); send(2, 8'h21, 1'b0); send(2, 8'h22, 1'b1);
    expect_wr(0, 8'h10); expect_wr(0, 8'h11); expect_wr(0, 8'h12);
    expect_wr(2, 8'h20); expect_wr(2, 8'h21); expect_wr(2, 8'h22);
    wait_idle();
    #1 send(0, 8'h30, 1'b1);
    expect_wr(0, 8'h30);
    wait_idle();
    #1 send(0, 8'h40, 1'b1); send(1, 8'h41, 1'b1); send(2, 8'h42, 1'b1);
    expect_wr(1, 8'h41); expect_wr(2, 8'h42); expect_wr(0, 8'h40);
    wait_idle();

    // 3: back-pressure mid-packet
    #1 timeout = 8'd16;
    send(1, 8'h61, 1'b0); send(1, 8'h62, 1'b0); send(1, 8'h63, 1'b1);
    expect_wr(1, 8'h61); expect_wr(1, 8'h62); expect_wr(1, 8'h63);
    wait_dwe(p);
    #1 tx_ready = 1'b0;
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dwe) pulses++;
      if (grant != 4'b0010) bad++;
    end
    chk("t3_no_pulse", pulses, 0);
    chk("t3_grant_held", bad, 0);
    #1 tx_ready = 1'b1;
    @(negedge clk);
    chk("t3_resume_pulse", dwe, 1);
    wait_idle();

    // 4: timeout revokes req1, req3 granted next
    #1 timeout = 8'd10;
    send(1, 8'hA1, 1'b0);
    expect_wr(1, 8'hA1);
    expect_wr(3, 8'h3C);
    wait_dwe(p);
    #1 send(3, 8'h3C, 1'b1);
    evt_q.push_back(p + 12);
    wait_evt(40);
    chk("t4_grant_revoked", grant, 0);
    chk("t4_busy", busy, 0);
    @(negedge clk);
    chk("t4_next_grant", grant, 4'b1000);
    wait_idle();

    // 5: timeout disabled; counter saturates
    #1 timeout = '0;
    send(0, 8'h70, 1'b0);
    expect_wr(0, 8'h70);
    wait_dwe(p);
    repeat (600) @(negedge clk);
    chk("t5_grant_held", grant, 4'b0001);
    chk("t5_busy", busy, 1);
    #1 timeout = 8'hFF;
    evt_q.push_back(cyc + 1);
    wait_evt(5);
    chk("t5_grant_revoked", grant, 0);
    #1 timeout = '0;

    // 6: enable abort, then asynchronous reset abort
    send(2, 8'h81, 1'b0); send(2, 8'h82, 1'b0); send(2, 8'h83, 1'b1);
    expect_wr(2, 8'h81);
    wait_dwe(p);
    #1 enable = 1'b0;
    rq[2].delete();
    @(negedge clk);
    chk("t6_en_busy", busy, 0);
    chk("t6_en_grant", grant, 0);
    chk("t6_en_dwe", dwe, 0);
    chk("t6_en_ready", ifc.req_ready, 0);
    #1 enable = 1'b1;
    @(negedge clk);
    chk("t6_stay_idle", busy, 0);
    #1 send(3, 8'h91, 1'b0); send(3, 8'h92, 1'b1);
    expect_wr(3, 8'h91);
    wait_dwe(p);
    @(negedge clk);
    #1 rst_n = 1'b0;
    rq[3].delete();
    #1;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_dwe", dwe, 0);
    chk("t6_rst_data", tx_data, 0);
    chk("t6_rst_ready", ifc.req_ready, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    send(0, 8'hA0, 1'b1); send(1, 8'hB0, 1'b1);
    expect_wr(0, 8'hA0); expect_wr(1, 8'hB0);
    wait_idle();

    chk("end_writes_drained", exp_q.size(), 0);
    chk("end_evts_drained", evt_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
